// File: rtl/sqrt_settle_monitor_if.sv
// Sample/status bundle between the amplifier loop and the settle monitor.
// The master drives the loop-side sample; the slave (the monitor) reports results.
interface sqrt_settle_monitor_if #(
  parameter int C_WIDTH = 16
) ();
  localparam int W = C_WIDTH + 6;

  logic                  enable;
  logic signed [W-1:0]   target;
  logic signed [W-1:0]   root;
  logic [2*W-1:0]        square;
  logic signed [2*W+1:0] error;
  logic                  sample_valid;
  logic                  locked;
  logic                  lock_lost;

  modport master (
    output enable, target, root,
    input  square, error, sample_valid, locked, lock_lost
  );

  modport slave (
    input  enable, target, root,
    output square, error, sample_valid, locked, lock_lost
  );
endinterface

// File: rtl/sqrt_settle_monitor.sv
// Settle monitor for the square-root amplifier loop: squares the captured root
// with a W-step shift-add multiplier, compares root^2 against the target within
// TOL, and asserts locked after LOCK_COUNT consecutive in-tolerance samples.
module sqrt_settle_monitor #(
  parameter int C_WIDTH    = 16,
  parameter int TOL        = 64,
  parameter int LOCK_COUNT = 8
) (
  input  logic                  clk_100k,
  input  logic                  reset_n,
  sqrt_settle_monitor_if.slave  bus
);
  localparam int W  = C_WIDTH + 6;
  localparam int EW = 2 * W + 2;
  localparam int CW = $clog2(W);

  localparam logic [W-1:0]  ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] ONE_E  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] TOL_E  = EW'(TOL);
  localparam logic [7:0]    LOCK_C = 8'(LOCK_COUNT);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Captured sample and multiplier working registers
  logic signed [W-1:0] r_target;
  logic [W-1:0]        r_mplier;
  logic [2*W-1:0]      r_mcand;
  logic [2*W-1:0]      r_acc;
  logic [CW-1:0]       r_bit_cnt;
  logic [7:0]          r_streak;

  // Result registers presented on the bus
  logic [2*W-1:0]      r_square;
  logic signed [EW-1:0] r_error;
  logic                r_sample_valid;
  logic                r_locked;
  logic                r_lock_lost;

  logic [W-1:0]        w_root_abs;
  logic signed [EW-1:0] w_err;
  logic [EW-1:0]       w_err_abs;
  logic                w_in_tol;
  logic [7:0]          w_streak_inc;
  logic                w_last_step;

  // |root| as unsigned W bits; the most negative input maps to 2^(W-1) exactly
  assign w_root_abs = bus.root[W-1] ? (~$unsigned(bus.root) + ONE_W) : $unsigned(bus.root);

  // Error is formed two bits wider than the square so it can never overflow
  assign w_err     = {{(EW-W){r_target[W-1]}}, r_target} - {2'b00, r_acc};
  assign w_err_abs = w_err[EW-1] ? (~$unsigned(w_err) + ONE_E) : $unsigned(w_err);
  assign w_in_tol  = (w_err_abs <= TOL_E);

  // Streak counter saturates so a long settled run keeps locked asserted
  assign w_streak_inc = (r_streak == LOCK_C) ? r_streak : (r_streak + 8'd1);
  assign w_last_step  = (r_bit_cnt == LAST_STEP);

  // State register; asynchronous reset aborts any in-flight sample
  always_ff @(posedge clk_100k or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic: IDLE waits for enable, MULT runs exactly W steps, DONE lasts one cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.enable) w_state_next = S_MULT;
      S_MULT:  if (w_last_step) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: capture, shift-add multiply, then publish result and update lock status
  always_ff @(posedge clk_100k or negedge reset_n) begin
    if (!reset_n) begin
      r_target       <= '0;
      r_mplier       <= '0;
      r_mcand        <= '0;
      r_acc          <= '0;
      r_bit_cnt      <= '0;
      r_streak       <= '0;
      r_square       <= '0;
      r_error        <= '0;
      r_sample_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_lock_lost    <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_lock_lost    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.enable) begin
            r_target  <= bus.target;
            r_mplier  <= w_root_abs;
            r_mcand   <= {{W{1'b0}}, w_root_abs};
            r_acc     <= '0;
            r_bit_cnt <= '0;
          end
        end
        S_MULT: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand   <= r_mcand << 1;
          r_mplier  <= r_mplier >> 1;
          r_bit_cnt <= r_bit_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
        S_DONE: begin
          r_square       <= r_acc;
          r_error        <= w_err;
          r_sample_valid <= 1'b1;
          if (w_in_tol) begin
            r_streak <= w_streak_inc;
            if (w_streak_inc == LOCK_C) r_locked <= 1'b1;
          end else begin
            r_streak    <= '0;
            r_locked    <= 1'b0;
            r_lock_lost <= r_locked;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.square       = r_square;
  assign bus.error        = r_error;
  assign bus.sample_valid = r_sample_valid;
  assign bus.locked       = r_locked;
  assign bus.lock_lost    = r_lock_lost;
endmodule

// File: tb/tb_sqrt_settle_monitor.sv
// Self-checking bench for sqrt_settle_monitor: directed scenarios followed by
// randomized samples, each compared against an arithmetic reference model.
module tb_sqrt_settle_monitor;
  localparam int C_WIDTH = 16;
  localparam int W       = C_WIDTH + 6;
  localparam int TOL     = 64;
  localparam int LC      = 8;

  logic clk_100k = 1'b0;
  logic reset_n  = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_streak  = 0;
  bit m_prev_ll = 1'b0;

  sqrt_settle_monitor_if #(.C_WIDTH(C_WIDTH)) bus ();

  sqrt_settle_monitor #(
    .C_WIDTH(C_WIDTH),
    .TOL(TOL),
    .LOCK_COUNT(LC)
  ) u_dut (
    .clk_100k(clk_100k),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk_100k = ~clk_100k;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // Drive one sample starting at a negedge with the DUT idle, wait for its
  // result (bounded), and compare against the model. Returns at a negedge.
  task automatic do_sample(input string tag, input longint t, input longint r, input bit drop_en);
    int n;
    bit seen;
    longint sq, er, ea;
    bit in_tol, exp_ll, exp_locked;
    bus.target = W'(t);
    bus.root   = W'(r);
    bus.enable = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk_100k);
      n++;
      @(negedge clk_100k);
      if (drop_en && n == 6) bus.enable = 1'b0;
      if (n == 1 && m_prev_ll) check({tag, ".ll_width"}, bus.lock_lost, 0);
      if (bus.sample_valid) seen = 1'b1;
    end
    sq = r * r;
    er = t - sq;
    ea = (er < 0) ? -er : er;
    in_tol = (ea <= TOL);
    exp_ll = (m_streak == LC) && !in_tol;
    if (in_tol) m_streak = (m_streak < LC) ? m_streak + 1 : LC;
    else        m_streak = 0;
    exp_locked = (m_streak == LC);
    m_prev_ll  = exp_ll;
    check({tag, ".latency"}, n, 24);
    check({tag, ".square"}, bus.square, sq);
    check({tag, ".error"}, bus.error, er);
    check({tag, ".locked"}, bus.locked, exp_locked);
    check({tag, ".lock_lost"}, bus.lock_lost, exp_ll);
    $display("sample %s: target=%0d root=%0d square=%0d error=%0d locked=%0b lock_lost=%0b",
             tag, t, r, bus.square, bus.error, bus.locked, bus.lock_lost);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".square"}, bus.square, 0);
    check({tag, ".error"}, bus.error, 0);
    check({tag, ".sample_valid"}, bus.sample_valid, 0);
    check({tag, ".locked"}, bus.locked, 0);
    check({tag, ".lock_lost"}, bus.lock_lost, 0);
  endtask

  initial begin
    int seen;
    longint r, t;
    int mode;

    bus.enable = 1'b0;
    bus.target = '0;
    bus.root   = '0;

    // Reset state
    repeat (2) @(negedge clk_100k);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk_100k);
    @(negedge clk_100k);
    check_all_zero("post_reset_idle");

    // Settled loop reaches lock on the 8th sample
    for (int i = 0; i < 8; i++) do_sample($sformatf("lock%0d", i), 10000, 100, 1'b0);

    // Tolerance boundary: inclusive at 64, out at 65 (drops lock)
    do_sample("tol64", 10064, 100, 1'b0);
    do_sample("tol65", 10065, 100, 1'b0);

    // Relock, then lose lock with root=101
    for (int i = 0; i < 8; i++) do_sample($sformatf("relock%0d", i), 10000, 100, 1'b0);
    do_sample("loss", 10000, 101, 1'b0);
    do_sample("after_loss", 10000, 100, 1'b0);

    // Negative and extreme roots
    do_sample("neg3", 9, -3, 1'b0);
    do_sample("min_root", 0, -2097152, 1'b0);
    do_sample("max_root", 0, 2097151, 1'b0);

    // Lock, then drop enable mid-MULT: sample completes, then block idles holding lock
    for (int i = 0; i < 8; i++) do_sample($sformatf("lock_b%0d", i), 10000, 100, 1'b0);
    do_sample("en_drop", 10000, 100, 1'b1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_100k);
      if (bus.sample_valid) seen++;
    end
    check("idle.no_sample", seen, 0);
    check("idle.locked_held", bus.locked, 1);
    check("idle.square_held", bus.square, 10000);
    do_sample("resume", 10000, 100, 1'b0);

    // Reset mid-MULT at E10: outputs clear at once, no sample reported
    bus.target = W'(10000);
    bus.root   = W'(100);
    bus.enable = 1'b1;
    repeat (11) @(posedge clk_100k);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    seen = 0;
    repeat (3) begin
      @(negedge clk_100k);
      if (bus.sample_valid) seen++;
    end
    check("reset.no_sample", seen, 0);
    reset_n   = 1'b1;
    m_streak  = 0;
    m_prev_ll = 1'b0;
    do_sample("post_reset", 10000, 100, 1'b0);

    // Randomized samples around and away from the settled point
    for (int i = 0; i < 30; i++) begin
      r = longint'($urandom_range(0, 2800)) - 1400;
      mode = $urandom_range(0, 3);
      case (mode)
        0:       t = r * r + (longint'($urandom_range(0, 160)) - 80);
        1:       t = r * r;
        2:       t = longint'($urandom_range(0, 4194303)) - 2097152;
        default: t = r * r + (($urandom_range(0, 1) == 1) ? TOL : TOL + 1)
                     * (($urandom_range(0, 1) == 1) ? 1 : -1);
      endcase
      do_sample($sformatf("rand%0d", i), t, r, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sqrt_settle_monitor.md
# sqrt_settle_monitor

Closed-loop checker for the square-root amplifier loop. It samples the loop's root output and the target input it was driven with, and squares the root with a sequential shift-add multiplier. It compares the square against the target within a tolerance and raises `locked` once the loop has stayed settled for a programmable number of consecutive samples. The block sits on the output side of the amplifier loop, runs on the same divided `clk_100k` domain, and feeds status/debug logic.

## Interface

Parameters:
- `C_WIDTH`, 16: base width; the data path is `W = C_WIDTH+6` bits (22 by default).
- `TOL`, 64: maximum accepted `|target - root^2|`, unsigned.
- `LOCK_COUNT`, 8: consecutive in-tolerance samples required to assert `locked`; range 1..255.

Ports:
- `clk_100k`, in, 1: block clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: level; permits capture of a new sample while in IDLE.
- `target`, in, W, signed: value the loop is solving, i.e. the loop's non-inverting input.
- `root`, in, W, signed: loop output under test.
- `square`, out, 2W, unsigned: last computed `root^2`.
- `error`, out, 2W+2, signed: last `target - square`.
- `sample_valid`, out, 1: one-cycle pulse when `square`, `error` and `locked` update.
- `locked`, out, 1: level; loop settled.
- `lock_lost`, out, 1: one-cycle pulse when `locked` falls.

## Operation

- FSM states are IDLE, MULT and DONE. Reset puts the FSM in IDLE with every output 0 and the streak counter 0.
- **IDLE**
  - If `enable`=1, capture `target` (sign-extended) and `|root|` as a W-bit unsigned multiplier and multiplicand.
  - Clear the accumulator and bit counter, then go to MULT.
  - If `enable`=0, stay in IDLE.
- **Absolute value**
  - `|root|` of `-2^(W-1)` is `2^(W-1)`, which fits unsigned W bits.
  - The square therefore never exceeds `2^(2W-2)`, so no saturation is needed.
- **MULT** (exactly W cycles)
  - If the multiplier LSB is 1, add the multiplicand to the accumulator (2W bits).
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - After the W-th step, go to DONE. No early termination.
- **DONE** (one cycle)
  - `square` <= accumulator.
  - `error` <= sign-extended target minus zero-extended accumulator, computed at 2W+2 bits with no overflow.
  - The sample is in tolerance when `|error| <= TOL`; the comparison is inclusive.
  - In tolerance: the streak counter increments, saturating at `LOCK_COUNT`. `locked` <= 1 when the incremented value equals `LOCK_COUNT`.
  - Out of tolerance: the streak counter <= 0 and `locked` <= 0. `lock_lost` pulses if `locked` was 1.
  - `sample_valid` <= 1, then go to IDLE.
- **Inputs outside IDLE:** `target` and `root` are ignored in MULT and DONE; only the captured copies are used.
- **`enable` falling:** if it falls during MULT or DONE, the in-flight sample completes and reports normally. Afterwards the block idles, and `locked` and the streak counter are held.
- **Negative `target`:** always out of tolerance, unless `TOL` ≥ `|error|`.

## Timing

- Call the capturing edge E0.
  - Edges E1..E22 are the multiply steps (W=22).
  - Edge E23 is DONE: outputs update and `sample_valid` rises.
  - Edge E24 clears `sample_valid` and, if `enable`=1, captures the next sample.
- With `enable` held high:
  - Sample period is exactly W+2 = 24 cycles.
  - Latency from capture to `sample_valid` is 23 cycles.
- `lock_lost` is coincident with the `sample_valid` of the failing sample.
- `locked` rises with the `sample_valid` of the `LOCK_COUNT`-th consecutive in-tolerance sample.
- Asynchronous reset in any state aborts the operation immediately. All outputs, the counter and the FSM return to reset values, and a capture is possible on the first edge after `reset_n` rises.
- `square`, `error` and `locked` hold their values between `sample_valid` pulses.

## Test plan

- **Settled loop, lock:** `root`=100, `target`=10000, `enable`=1 for 8 samples. Each sample gives `square`=10000 and `error`=0. `locked`=1 from the 8th `sample_valid`; `sample_valid` period is 24 cycles.
- **Tolerance boundary:** `root`=100 with `target`=10064 gives `error`=64, in tolerance. `target`=10065 gives `error`=65, out of tolerance: the streak counter resets and, if locked, `locked`=0 and `lock_lost` pulses once.
- **Negative and extreme roots:**
  - `root`=-3, `target`=9: `square`=9, `error`=0.
  - `root`=-2097152: `square`=4398046511104.
  - `root`=2097151: `square`=4398042316801.
- **Loss after lock:** lock as in the first scenario, then `root`=101 with `target`=10000. Required: `error`=-201, `locked` falls, `lock_lost` pulses for exactly 1 cycle, and the next good sample leaves `locked`=0 (streak counter at 1).
- **Enable drop mid-MULT:** deassert `enable` at E5. The sample still reports at E23, no capture follows, and `locked` is held.
- **Reset mid-MULT:** assert `reset_n`=0 at E10. All outputs go to 0 immediately, with no `sample_valid`. After release with `enable`=1, the first result appears 23 cycles after the capturing edge.
